// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parameterised register file with two synchronous read ports, one write
// port and a per-register "pending" scoreboard. A pending bit marks a
// register whose producer is still in flight. It is set by Reserve and
// cleared by the write that finally delivers the value.
//
// Parameters
//   WIDTH     data bits per register
//   DEPTH     number of registers (power of two, 2..256)
//   ADDR_W    address bits, log2(DEPTH)
//   ZERO_REG  1: register 0 reads as zero, ignores writes and reserves
//
// Ports
//   Clk              clock, all state changes on the rising edge
//   Reset_n          asynchronous active-low reset, clears every flop
//   WriteData        data for the write port
//   WriteRegister    write address
//   RegWrite         write enable
//   ReadRegister1/2  read addresses, ports 1 and 2
//   ReadEnable       capture both read ports at this edge
//   Reserve          mark ReserveRegister pending at this edge
//   ReserveRegister  address to mark pending
//   ReadData1/2      registered read data
//   Busy1/2          registered pending flag of the captured address
//   ReadValid        one-cycle strobe after a ReadEnable capture
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic              ReadEnable,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegister,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    output logic              ReadValid
);

    localparam logic ZERO_EN = (ZERO_REG != 32'd0);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DEPTH-1:0]  ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

    // Storage and pending scoreboard
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Registered read side
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic [WIDTH-1:0] rdata2_q, rdata2_d;
    logic             busy1_q, busy1_d;
    logic             busy2_q, busy2_d;
    logic             valid_q, valid_d;

    // Qualified write/reserve requests
    logic             wr_en_s;
    logic             rs_en_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] set_mask_s;
    logic             rd1_zero_s;
    logic             rd2_zero_s;
    logic             hit1_s;
    logic             hit2_s;

    // Drop writes/reserves aimed at the hard-wired zero register.
    assign wr_en_s    = RegWrite & ~(ZERO_EN & (WriteRegister == ADDR_ZERO));
    assign rs_en_s    = Reserve  & ~(ZERO_EN & (ReserveRegister == ADDR_ZERO));
    assign rd1_zero_s = ZERO_EN & (ReadRegister1 == ADDR_ZERO);
    assign rd2_zero_s = ZERO_EN & (ReadRegister2 == ADDR_ZERO);
    assign hit1_s     = RegWrite & (WriteRegister == ReadRegister1);
    assign hit2_s     = RegWrite & (WriteRegister == ReadRegister2);

    // Pending update: the write clears first, then a same-edge reserve sets,
    // so a reserve of the address being written leaves the bit set.
    always_comb begin
        clr_mask_s = {DEPTH{1'b0}};
        set_mask_s = {DEPTH{1'b0}};
        if (RegWrite) begin
            clr_mask_s = ONE_HOT0 << WriteRegister;
        end else begin
            clr_mask_s = {DEPTH{1'b0}};
        end
        if (rs_en_s) begin
            set_mask_s = ONE_HOT0 << ReserveRegister;
        end else begin
            set_mask_s = {DEPTH{1'b0}};
        end
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
    end

    // Read port 1 next state: write-first bypass on data; busy uses the
    // pre-edge pending bit masked by a same-edge write (reserve not visible).
    always_comb begin
        rdata1_d = rdata1_q;
        busy1_d  = busy1_q;
        if (ReadEnable) begin
            if (rd1_zero_s) begin
                rdata1_d = {WIDTH{1'b0}};
                busy1_d  = 1'b0;
            end else begin
                rdata1_d = (wr_en_s && hit1_s) ? WriteData : mem_q[ReadRegister1];
                busy1_d  = pending_q[ReadRegister1] & ~hit1_s;
            end
        end else begin
            rdata1_d = rdata1_q;
            busy1_d  = busy1_q;
        end
    end

    // Read port 2 next state, identical to port 1 on its own address.
    always_comb begin
        rdata2_d = rdata2_q;
        busy2_d  = busy2_q;
        if (ReadEnable) begin
            if (rd2_zero_s) begin
                rdata2_d = {WIDTH{1'b0}};
                busy2_d  = 1'b0;
            end else begin
                rdata2_d = (wr_en_s && hit2_s) ? WriteData : mem_q[ReadRegister2];
                busy2_d  = pending_q[ReadRegister2] & ~hit2_s;
            end
        end else begin
            rdata2_d = rdata2_q;
            busy2_d  = busy2_q;
        end
    end

    // Read-valid strobe follows the enable by one edge.
    always_comb begin
        valid_d = ReadEnable;
    end

    // Register array write port with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[WriteRegister] <= WriteData;
        end
    end

    // Pending vector and registered read outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_q <= {DEPTH{1'b0}};
            rdata1_q  <= {WIDTH{1'b0}};
            rdata2_q  <= {WIDTH{1'b0}};
            busy1_q   <= 1'b0;
            busy2_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            busy1_q   <= busy1_d;
            busy2_q   <= busy2_d;
            valid_q   <= valid_d;
        end
    end

    assign ReadData1 = rdata1_q;
    assign ReadData2 = rdata2_q;
    assign Busy1     = busy1_q;
    assign Busy2     = busy2_q;
    assign ReadValid = valid_q;

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Bench for regfile_param. Instance A uses the default configuration
// (32x32, zero register). Instance B is 8x8 with a writable register 0.
// Each issued read pushes its expected result, taken from a reference
// model, into a queue. The entry is popped and compared one edge later,
// when the read result is registered.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: 32x32, ZERO_REG=1 ----------------
    logic        rst_a;
    logic [31:0] wd_a;
    logic [4:0]  wa_a, r1_a, r2_a, ra_a;
    logic        we_a, re_a, rs_a;
    logic [31:0] d1_a, d2_a;
    logic        b1_a, b2_a, v_a;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (
        .Clk(Clk), .Reset_n(rst_a), .WriteData(wd_a), .WriteRegister(wa_a),
        .RegWrite(we_a), .ReadRegister1(r1_a), .ReadRegister2(r2_a),
        .ReadEnable(re_a), .Reserve(rs_a), .ReserveRegister(ra_a),
        .ReadData1(d1_a), .ReadData2(d2_a), .Busy1(b1_a), .Busy2(b2_a),
        .ReadValid(v_a)
    );

    // ---------------- instance B: 8x8, ZERO_REG=0 ----------------
    logic       rst_b;
    logic [7:0] wd_b;
    logic [2:0] wa_b, r1_b, r2_b, ra_b;
    logic       we_b, re_b, rs_b;
    logic [7:0] d1_b, d2_b;
    logic       b1_b, b2_b, v_b;

    regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) dut_b (
        .Clk(Clk), .Reset_n(rst_b), .WriteData(wd_b), .WriteRegister(wa_b),
        .RegWrite(we_b), .ReadRegister1(r1_b), .ReadRegister2(r2_b),
        .ReadEnable(re_b), .Reserve(rs_b), .ReserveRegister(ra_b),
        .ReadData1(d1_b), .ReadData2(d2_b), .Busy1(b1_b), .Busy2(b2_b),
        .ReadValid(v_b)
    );

    // Reference state
    logic [31:0] ma [32];
    logic [31:0] pa;
    logic [7:0]  mb [8];
    logic [7:0]  pb;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        last_a;
    exp_t        last_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model_a();
        for (int i = 0; i < 32; i++) ma[i] = 32'd0;
        pa = 32'd0;
        q_a.delete();
        last_a = '{32'd0, 32'd0, 1'b0, 1'b0};
    endtask

    task automatic clear_model_b();
        for (int i = 0; i < 8; i++) mb[i] = 8'd0;
        pb = 8'd0;
        q_b.delete();
        last_b = '{32'd0, 32'd0, 1'b0, 1'b0};
    endtask

    // One clock of instance A: drive, predict, step, compare.
    task automatic cyc_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] r1, input logic [4:0] r2,
                         input logic rs, input logic [4:0] ra);
        exp_t e;
        we_a = we; wa_a = wa; wd_a = wd;
        re_a = re; r1_a = r1; r2_a = r2;
        rs_a = rs; ra_a = ra;
        if (re) begin
            e.d1 = (r1 == 5'd0) ? 32'd0 : ((we && wa == r1) ? wd : ma[r1]);
            e.b1 = (r1 != 5'd0) && pa[r1] && !(we && wa == r1);
            e.d2 = (r2 == 5'd0) ? 32'd0 : ((we && wa == r2) ? wd : ma[r2]);
            e.b2 = (r2 != 5'd0) && pa[r2] && !(we && wa == r2);
            q_a.push_back(e);
        end
        if (we && wa != 5'd0) ma[wa] = wd;
        if (we) pa[wa] = 1'b0;
        if (rs && ra != 5'd0) pa[ra] = 1'b1;
        @(posedge Clk);
        #1;
        check_val("a_valid", {31'd0, v_a}, {31'd0, re});
        if (re && q_a.size() > 0) begin
            e = q_a.pop_front();
            last_a = e;
            check_val("a_d1", d1_a, e.d1);
            check_val("a_d2", d2_a, e.d2);
            check_val("a_b1", {31'd0, b1_a}, {31'd0, e.b1});
            check_val("a_b2", {31'd0, b2_a}, {31'd0, e.b2});
        end else begin
            check_val("a_hold_d1", d1_a, last_a.d1);
            check_val("a_hold_d2", d2_a, last_a.d2);
            check_val("a_hold_b1", {31'd0, b1_a}, {31'd0, last_a.b1});
        end
    endtask

    // One clock of instance B.
    task automatic cyc_b(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] r1, input logic [2:0] r2,
                         input logic rs, input logic [2:0] ra);
        exp_t e;
        we_b = we; wa_b = wa; wd_b = wd;
        re_b = re; r1_b = r1; r2_b = r2;
        rs_b = rs; ra_b = ra;
        if (re) begin
            e.d1 = {24'd0, (we && wa == r1) ? wd : mb[r1]};
            e.b1 = pb[r1] && !(we && wa == r1);
            e.d2 = {24'd0, (we && wa == r2) ? wd : mb[r2]};
            e.b2 = pb[r2] && !(we && wa == r2);
            q_b.push_back(e);
        end
        if (we) begin
            mb[wa] = wd;
            pb[wa] = 1'b0;
        end
        if (rs) pb[ra] = 1'b1;
        @(posedge Clk);
        #1;
        check_val("b_valid", {31'd0, v_b}, {31'd0, re});
        if (re && q_b.size() > 0) begin
            e = q_b.pop_front();
            last_b = e;
            check_val("b_d1", {24'd0, d1_b}, e.d1);
            check_val("b_d2", {24'd0, d2_b}, e.d2);
            check_val("b_b1", {31'd0, b1_b}, {31'd0, e.b1});
            check_val("b_b2", {31'd0, b2_b}, {31'd0, e.b2});
        end else begin
            check_val("b_hold_d1", {24'd0, d1_b}, last_b.d1);
            check_val("b_hold_b1", {31'd0, b1_b}, {31'd0, last_b.b1});
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        we_a = 1'b0; wa_a = 5'd0; wd_a = 32'd0; re_a = 1'b0; r1_a = 5'd0; r2_a = 5'd0; rs_a = 1'b0; ra_a = 5'd0;
        we_b = 1'b0; wa_b = 3'd0; wd_b = 8'd0; re_b = 1'b0; r1_b = 3'd0; r2_b = 3'd0; rs_b = 1'b0; ra_b = 3'd0;
        clear_model_a();
        clear_model_b();
        #12;
        // Reset state
        check_val("rst_a_d1", d1_a, 32'd0);
        check_val("rst_a_valid", {31'd0, v_a}, 32'd0);
        check_val("rst_b_d1", {24'd0, d1_b}, 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;

        // ---------- instance A directed ----------
        cyc_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0);
        check_val("r34_d1", d1_a, 32'hDEADBEEF);
        check_val("r34_d2", d2_a, 32'hDEADBEEF);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        check_val("r34_valid_once", {31'd0, v_a}, 32'd0);

        cyc_a(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd5, 1'b0, 5'd0);
        check_val("r35_bypass", d1_a, 32'h12345678);

        cyc_a(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        check_val("r36_zero_d", d1_a, 32'd0);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0);
        cyc_a(1'b1, 5'd0, 32'h0000FFFF, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        check_val("r36_zero_busy", {31'd0, b1_a}, 32'd0);

        cyc_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0);
        check_val("r37_busy", {31'd0, b1_a}, 32'd1);
        cyc_a(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 1'b0, 5'd0);
        check_val("r37_data", d1_a, 32'hA5A5A5A5);
        check_val("r37_still_busy", {31'd0, b1_a}, 32'd1);
        // same-edge reserve is not visible to that capture
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd4);
        check_val("r27_rs_hidden", {31'd0, b1_a}, 32'd0);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 1'b0, 5'd0);
        check_val("r27_rs_seen", {31'd0, b2_a}, 32'd1);

        // Random traffic on a narrow address range to force collisions
        for (int i = 0; i < 300; i++) begin
            cyc_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        // Fill with own index, make r31 pending, then reset mid-read
        for (int i = 0; i < 32; i++) begin
            cyc_a(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        end
        cyc_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd31);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd30, 1'b0, 5'd0);
        check_val("r38_pre_d1", d1_a, 32'd31);
        #2;
        rst_a = 1'b0;
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hCAFEF00D; re_a = 1'b1; rs_a = 1'b1; ra_a = 5'd10;
        #1;
        check_val("r38_async_d1", d1_a, 32'd0);
        check_val("r38_async_d2", d2_a, 32'd0);
        check_val("r38_async_b1", {31'd0, b1_a}, 32'd0);
        check_val("r38_async_valid", {31'd0, v_a}, 32'd0);
        @(posedge Clk);
        #1;
        check_val("r31_ignored_valid", {31'd0, v_a}, 32'd0);
        we_a = 1'b0; re_a = 1'b0; rs_a = 1'b0;
        #2;
        rst_a = 1'b1;
        clear_model_a();
        cyc_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd9, 1'b0, 5'd0);
        check_val("r38_post_r31", d1_a, 32'd0);
        check_val("r38_post_r9", d2_a, 32'd0);
        cyc_a(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd31, 1'b0, 5'd0);

        // ---------- instance B directed ----------
        cyc_b(1'b1, 3'd0, 8'h5A, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        cyc_b(1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
        check_val("r39_r0_data", {24'd0, d1_b}, 32'h5A);
        cyc_b(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0);
        cyc_b(1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 3'd1, 1'b0, 3'd0);
        check_val("r39_r0_busy", {31'd0, b1_b}, 32'd1);
        cyc_b(1'b1, 3'd5, 8'hEF, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        cyc_b(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 3'd5, 1'b0, 3'd0);
        cyc_b(1'b1, 3'd0, 8'h33, 1'b1, 3'd0, 3'd7, 1'b0, 3'd0);
        check_val("r39_r0_bypass", {24'd0, d1_b}, 32'h33);
        cyc_b(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3);
        cyc_b(1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 3'd3, 1'b0, 3'd0);
        check_val("r39_r3_busy", {31'd0, b1_b}, 32'd1);
        for (int i = 0; i < 200; i++) begin
            cyc_b(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom()),
                  1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 8; i++) begin
            cyc_b(1'b1, 3'(i), 8'(i), 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        end
        cyc_b(1'b0, 3'd0, 8'd0, 1'b1, 3'd7, 3'd6, 1'b0, 3'd0);
        #2;
        rst_b = 1'b0;
        #1;
        check_val("r39_async_d1", {24'd0, d1_b}, 32'd0);
        check_val("r39_async_valid", {31'd0, v_b}, 32'd0);
        #3;
        rst_b = 1'b1;
        clear_model_b();
        cyc_b(1'b0, 3'd0, 8'd0, 1'b1, 3'd7, 3'd0, 1'b0, 3'd0);
        check_val("r39_post_r7", {24'd0, d1_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, 2..256).
REQ-003 SHALL have parameter ADDR_W, default 5, address bits; SHALL equal log2(DEPTH).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is read-only zero.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Clk  input  1  clock; all state updates on the rising edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 WriteData  input  WIDTH  data to write.
REQ-009 WriteRegister  input  ADDR_W  write address.
REQ-010 RegWrite  input  1  write enable, high = write this edge.
REQ-011 ReadRegister1, ReadRegister2  input  ADDR_W each  read addresses, ports 1 and 2.
REQ-012 ReadEnable  input  1  high = capture both read ports this edge.
REQ-013 Reserve  input  1  high = mark ReserveRegister pending (producer in flight).
REQ-014 ReserveRegister  input  ADDR_W  address to mark pending.
REQ-015 ReadData1, ReadData2  output  WIDTH each  registered read data.
REQ-016 Busy1, Busy2  output  1 each  registered pending flag of the captured address.
REQ-017 ReadValid  output  1  high for one cycle after a ReadEnable capture.

Function
REQ-018 Storage SHALL be DEPTH x WIDTH flops plus a DEPTH-bit pending vector.
REQ-019 On a rising edge with RegWrite=1, register[WriteRegister] SHALL take WriteData, except that with ZERO_REG=1 writes to address 0 SHALL be dropped.
REQ-020 Reads SHALL be synchronous with 1-cycle latency: ReadEnable=1 at edge N loads ReadData1/2, Busy1/2 and sets ReadValid=1 after edge N.
REQ-021 With ReadEnable=0 at an edge, ReadData1/2 and Busy1/2 SHALL hold and ReadValid SHALL be 0.
REQ-022 Write-first bypass: if RegWrite=1 and WriteRegister equals ReadRegisterX at the same capturing edge, and the write is not dropped, ReadDataX SHALL be WriteData.
REQ-023 With ZERO_REG=1, a read of address 0 SHALL return all zeros and BusyX=0 in every case.
REQ-024 Reserve=1 at an edge SHALL set pending[ReserveRegister]; with ZERO_REG=1, a reserve of address 0 SHALL be ignored.
REQ-025 RegWrite=1 at an edge SHALL clear pending[WriteRegister].
REQ-026 Reserve and RegWrite to the same address at the same edge: pending SHALL end set (reserve wins), and the data write SHALL still occur.
REQ-027 BusyX captured SHALL equal the pre-edge pending[ReadRegisterX] AND NOT (same-edge write to that address); a same-edge reserve SHALL NOT be visible until the next capture.
REQ-028 Both read ports SHALL be fully independent; identical read addresses SHALL return identical data and busy values.
REQ-029 No stall or backpressure SHALL exist; every edge SHALL accept a write, a reserve and a read at once.

Reset
REQ-030 Reset_n=0 SHALL immediately, without waiting for a clock edge, clear all registers, all pending bits, ReadData1/2, Busy1/2 and ReadValid to 0.
REQ-031 While Reset_n=0, RegWrite, Reserve and ReadEnable SHALL be ignored.
REQ-032 An assertion of reset in the middle of a read SHALL clear that read; ReadValid SHALL be 0 in the first cycle after release unless a new ReadEnable is sampled at that edge.
REQ-033 Reset release SHALL be synchronous to Clk by the integrator; the first edge after release SHALL perform normal operation.

Verification
REQ-034 Write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> ReadData1=ReadData2=0xDEADBEEF, ReadValid=1 for exactly one cycle.
REQ-035 Same edge: RegWrite r7=0x12345678 and ReadEnable with ReadRegister1=7 -> ReadData1=0x12345678 after that edge (bypass).
REQ-036 ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 -> ReadData=0, Busy=0; reserve r0 then read -> Busy=0.
REQ-037 Reserve r3; next edge read r3 -> Busy1=1. Then write r3=0xA5A5A5A5 at the same edge as a reserve of r3 -> pending stays set; the next read returns 0xA5A5A5A5 with Busy1=1.
REQ-038 Fill all registers with their own index, pulse Reset_n low between clock edges -> outputs drop to 0 at once; a read of r31 after release returns 0.
REQ-039 Rerun REQ-034..038 with WIDTH=8, DEPTH=8, ADDR_W=3, ZERO_REG=0 -> r0 is writable and reservable; a write of 0x5A to r0 reads back 0x5A.
